controle_giro_360: RTL and testbench

- Timed rotation sequencer that drives the 1-bit `largura` (stop/go) input of the continuous-rotation servo PWM stage.
- Accepts a move command of 1–3 quarter-turns from the cube-solving move sequencer.
- Holds the servo "go" for an exact number of clock cycles per quarter-turn, then enforces a settle pause.
- Reports completion with a one-cycle `pronto` pulse; one instance per face servo.

---
 rtl/servo_pkg.sv | 23 ++
 rtl/controle_giro_360_if.sv | 25 ++
 rtl/contador_tempo.sv | 28 ++
 rtl/controle_giro_360.sv | 158 +++++++++++++++
 tb/tb_controle_giro_360.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the face-servo rotation sequencer: FSM states,
// 50 MHz timing defaults and the quarter-turn encoding.
package servo_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    GIRANDO = 2'd1,
    PAUSA   = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int unsigned CICLOS_QUARTO_50MHZ = 12500000;
  localparam int unsigned CICLOS_PAUSA_50MHZ  = 2500000;

  localparam int unsigned LARG_QUARTOS = 2;
  typedef logic [LARG_QUARTOS-1:0] quartos_t;

  localparam quartos_t QUARTOS_NENHUM = 2'd0;
  localparam quartos_t QUARTOS_90     = 2'd1;
  localparam quartos_t QUARTOS_180    = 2'd2;
  localparam quartos_t QUARTOS_270    = 2'd3;

endpackage

// File: rtl/controle_giro_360_if.sv
// Command/status bundle between the move sequencer (master) and one face
// rotation controller (slave).
interface controle_giro_360_if;
  import servo_pkg::*;

  logic     iniciar;
  quartos_t quartos;
  logic     cancelar;
  logic     largura;
  logic     ocupado;
  logic     pronto;
  logic     abortado;
  quartos_t quartos_feitos;

  modport master (
    output iniciar, quartos, cancelar,
    input  largura, ocupado, pronto, abortado, quartos_feitos
  );

  modport slave (
    input  iniciar, quartos, cancelar,
    output largura, ocupado, pronto, abortado, quartos_feitos
  );

endinterface

// File: rtl/contador_tempo.sv
// Loadable down-counter that saturates at zero; the owner decides every load.
module contador_tempo #(
  parameter int unsigned LARG_CONT = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 carrega,
  input  logic [LARG_CONT-1:0] valor,
  input  logic                 habilita,
  output logic                 zero
);

  logic [LARG_CONT-1:0] r_contagem;

  // Load has priority over counting; never wraps below zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_contagem <= '0;
    end else if (carrega) begin
      r_contagem <= valor;
    end else if (habilita && (r_contagem != '0)) begin
      r_contagem <= r_contagem - LARG_CONT'(1);
    end
  end

  assign zero = (r_contagem == '0);

endmodule

// File: rtl/controle_giro_360.sv
// Timed rotation sequencer: holds the servo "go" for a whole number of
// quarter-turns, then a settle pause, then reports completion.
module controle_giro_360
  import servo_pkg::*;
#(
  parameter int unsigned CICLOS_QUARTO = CICLOS_QUARTO_50MHZ,
  parameter int unsigned CICLOS_PAUSA  = CICLOS_PAUSA_50MHZ,
  parameter int unsigned LARG_CONT     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  controle_giro_360_if.slave    bus
);

  localparam logic [LARG_CONT-1:0] RECARGA_QUARTO = LARG_CONT'(CICLOS_QUARTO - 1);
  localparam logic [LARG_CONT-1:0] RECARGA_PAUSA  = LARG_CONT'(CICLOS_PAUSA - 1);

  estado_t  r_estado;
  logic     r_largura;
  logic     r_ocupado;
  logic     r_pronto;
  logic     r_abortado;
  quartos_t r_quartos_feitos;
  quartos_t r_quartos;

  estado_t              w_estado_prox;
  logic                 w_largura_prox;
  logic                 w_ocupado_prox;
  logic                 w_pronto_prox;
  logic                 w_abortado_prox;
  quartos_t             w_quartos_feitos_prox;
  quartos_t             w_quartos_prox;
  quartos_t             w_quartos_mais_um;
  logic                 w_carrega;
  logic [LARG_CONT-1:0] w_valor;
  logic                 w_habilita;
  logic                 w_zero;

  contador_tempo #(
    .LARG_CONT (LARG_CONT)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .carrega  (w_carrega),
    .valor    (w_valor),
    .habilita (w_habilita),
    .zero     (w_zero)
  );

  assign w_quartos_mais_um = quartos_t'(r_quartos_feitos + quartos_t'(1));

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado         <= OCIOSO;
      r_largura        <= 1'b0;
      r_ocupado        <= 1'b0;
      r_pronto         <= 1'b0;
      r_abortado       <= 1'b0;
      r_quartos_feitos <= '0;
      r_quartos        <= '0;
    end else begin
      r_estado         <= w_estado_prox;
      r_largura        <= w_largura_prox;
      r_ocupado        <= w_ocupado_prox;
      r_pronto         <= w_pronto_prox;
      r_abortado       <= w_abortado_prox;
      r_quartos_feitos <= w_quartos_feitos_prox;
      r_quartos        <= w_quartos_prox;
    end
  end

  // Next-state, next-output and counter control.
  always_comb begin
    w_estado_prox         = r_estado;
    w_largura_prox        = r_largura;
    w_ocupado_prox        = r_ocupado;
    w_pronto_prox         = 1'b0;
    w_abortado_prox       = r_abortado;
    w_quartos_feitos_prox = r_quartos_feitos;
    w_quartos_prox        = r_quartos;
    w_carrega             = 1'b0;
    w_valor               = '0;
    w_habilita            = 1'b0;

    unique case (r_estado)
      OCIOSO: begin
        if (bus.iniciar) begin
          w_quartos_prox        = bus.quartos;
          w_quartos_feitos_prox = '0;
          w_abortado_prox       = 1'b0;
          w_ocupado_prox        = 1'b1;
          if (bus.quartos != QUARTOS_NENHUM) begin
            w_largura_prox = 1'b1;
            w_carrega      = 1'b1;
            w_valor        = RECARGA_QUARTO;
            w_estado_prox  = GIRANDO;
          end else begin
            w_estado_prox  = FIM;
          end
        end
      end

      GIRANDO: begin
        w_habilita = 1'b1;
        // A quarter finishing on the same edge as a cancel still counts.
        if (w_zero) begin
          w_quartos_feitos_prox = w_quartos_mais_um;
        end
        if (bus.cancelar) begin
          w_largura_prox  = 1'b0;
          w_abortado_prox = 1'b1;
          w_carrega       = 1'b1;
          w_valor         = RECARGA_PAUSA;
          w_estado_prox   = PAUSA;
        end else if (w_zero) begin
          w_carrega = 1'b1;
          if (w_quartos_mais_um == r_quartos) begin
            w_largura_prox = 1'b0;
            w_valor        = RECARGA_PAUSA;
            w_estado_prox  = PAUSA;
          end else begin
            w_valor        = RECARGA_QUARTO;
          end
        end
      end

      PAUSA: begin
        w_habilita = 1'b1;
        if (w_zero) begin
          w_pronto_prox = 1'b1;
          w_estado_prox = FIM;
        end
      end

      FIM: begin
        // A zero-turn command arrives here without pronto raised yet.
        if (r_pronto) begin
          w_ocupado_prox = 1'b0;
          w_estado_prox  = OCIOSO;
        end else begin
          w_pronto_prox  = 1'b1;
        end
      end

      default: begin
        w_estado_prox = OCIOSO;
      end
    endcase
  end

  assign bus.largura        = r_largura;
  assign bus.ocupado        = r_ocupado;
  assign bus.pronto         = r_pronto;
  assign bus.abortado       = r_abortado;
  assign bus.quartos_feitos = r_quartos_feitos;

endmodule

// File: tb/tb_controle_giro_360.sv
// Bench for controle_giro_360: directed scenarios plus random commands,
// checked every cycle against a timeline model of each move.
module tb_controle_giro_360;

  localparam int CQ = 10;
  localparam int CP = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  controle_giro_360_if bus ();

  controle_giro_360 #(
    .CICLOS_QUARTO (CQ),
    .CICLOS_PAUSA  (CP),
    .LARG_CONT     (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vetores = 0;
  int n_erros   = 0;
  int borda     = 0;

  // Timeline of the current/last move, as edge numbers.
  bit m_valido;
  int m_inicio;
  int m_fim_mov;
  int m_fim;
  int m_q;
  bit m_abort;
  int m_borda_cancel;

  task automatic verifica(input string tag, input int obtido, input int esperado);
    n_vetores++;
    if (obtido !== esperado) begin
      n_erros++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, borda, obtido, esperado);
    end
  endtask

  task automatic modelo_borda(input bit ini, input int q, input bit can, input bit rst);
    if (!rst) begin
      m_valido = 1'b0;
    end else if (ini && (!m_valido || borda >= m_fim + 2)) begin
      m_valido  = 1'b1;
      m_inicio  = borda;
      m_q       = q;
      m_fim_mov = borda + q * CQ;
      m_fim     = (q == 0) ? borda + 1 : m_fim_mov + CP;
      m_abort   = 1'b0;
    end else if (m_valido && can && m_q != 0 && borda > m_inicio && borda <= m_fim_mov) begin
      m_fim_mov      = borda;
      m_fim          = borda + CP;
      m_abort        = 1'b1;
      m_borda_cancel = borda;
    end
  endtask

  task automatic compara();
    int e_lar, e_ocu, e_pro, e_ab, e_qf;
    e_lar = 0; e_ocu = 0; e_pro = 0; e_ab = 0; e_qf = 0;
    if (m_valido) begin
      e_lar = (borda >= m_inicio && borda < m_fim_mov) ? 1 : 0;
      e_ocu = (borda >= m_inicio && borda <= m_fim) ? 1 : 0;
      e_pro = (borda == m_fim) ? 1 : 0;
      e_ab  = (m_abort && borda >= m_borda_cancel) ? 1 : 0;
      e_qf  = (borda < m_fim_mov) ? (borda - m_inicio) / CQ : (m_fim_mov - m_inicio) / CQ;
    end
    verifica("largura",        int'(bus.largura),        e_lar);
    verifica("ocupado",        int'(bus.ocupado),        e_ocu);
    verifica("pronto",         int'(bus.pronto),         e_pro);
    verifica("abortado",       int'(bus.abortado),       e_ab);
    verifica("quartos_feitos", int'(bus.quartos_feitos), e_qf);
  endtask

  // Drive inputs from a negedge, clock one edge, then check mid-cycle.
  task automatic passo(input bit ini, input int q, input bit can);
    bus.iniciar  = ini;
    bus.quartos  = 2'(q);
    bus.cancelar = can;
    @(posedge clock);
    borda++;
    modelo_borda(ini, q, can, reset);
    @(negedge clock);
    compara();
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) passo(1'b0, 0, 1'b0);
  endtask

  initial begin
    m_valido = 1'b0;
    m_abort  = 1'b0;
    reset        = 1'b0;
    bus.iniciar  = 1'b0;
    bus.quartos  = 2'd0;
    bus.cancelar = 1'b0;

    // Held in reset: everything at zero, commands ignored.
    ocioso(2);
    passo(1'b1, 2, 1'b0);
    reset = 1'b1;
    ocioso(2);

    // Single quarter-turn.
    passo(1'b1, 1, 1'b0);
    ocioso(20);

    // Three quarters back to back.
    passo(1'b1, 3, 1'b0);
    ocioso(40);

    // Two quarters, cancelled during cycle 13 of motion.
    passo(1'b1, 2, 1'b0);
    ocioso(12);
    passo(1'b0, 0, 1'b1);
    ocioso(10);

    // Zero-turn command.
    passo(1'b1, 0, 1'b0);
    ocioso(5);

    // Re-strobes while busy are dropped; first idle cycle after FIM accepts.
    passo(1'b1, 3, 1'b0);
    for (int i = 0; i < 36; i++) passo(1'b1, 1, 1'b0);
    ocioso(16);

    // Cancel ignored outside motion.
    passo(1'b1, 1, 1'b0);
    ocioso(10);
    for (int i = 0; i < 8; i++) passo(1'b0, 0, 1'b1);

    // Asynchronous reset between edges while rotating.
    passo(1'b1, 3, 1'b0);
    ocioso(7);
    #2 reset = 1'b0;
    #1;
    m_valido = 1'b0;
    compara();
    ocioso(2);
    reset = 1'b1;
    passo(1'b1, 1, 1'b0);
    ocioso(16);

    // Random commands and cancels, with an occasional reset pulse.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        #1 reset = 1'b0;
        #1;
        m_valido = 1'b0;
        compara();
        ocioso(1);
        reset = 1'b1;
      end
      passo($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
